// File: rtl/obstacle_scheduler_if.sv
// Signal bundle between the obstacle scheduler and the game/obstacle logic around it.
// The scheduler takes the slave side; the game screen and obstacle drivers take the master side.
interface obstacle_scheduler_if;
  logic        game_on;
  logic        menu_on;
  logic        play_selected;
  logic [3:0]  obst_done;
  logic [11:0] rgb_bg;
  logic [47:0] rgb_obst;
  logic [47:0] obst_x_in;
  logic [47:0] obst_y_in;
  logic [3:0]  selected;
  logic        start;
  logic [11:0] rgb_out;
  logic [11:0] obstacle_x;
  logic [11:0] obstacle_y;
  logic [7:0]  round_count;
  logic        timeout_err;

  modport master (
    output game_on, menu_on, play_selected, obst_done,
    output rgb_bg, rgb_obst, obst_x_in, obst_y_in,
    input  selected, start, rgb_out, obstacle_x, obstacle_y, round_count, timeout_err
  );

  modport slave (
    input  game_on, menu_on, play_selected, obst_done,
    input  rgb_bg, rgb_obst, obst_x_in, obst_y_in,
    output selected, start, rgb_out, obstacle_x, obstacle_y, round_count, timeout_err
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// Rotates through the enabled obstacles: start pulse, run until done or timeout, idle gap, next.
// Also muxes the active obstacle's pixel and hit coordinates onto the shared outputs.
module obstacle_scheduler #(
  parameter int unsigned GAP_CYCLES     = 16000000,
  parameter int unsigned TIMEOUT_CYCLES = 320000000,
  parameter logic [3:0]  ENABLE_MASK    = 4'b1111
) (
  input  logic          clk,
  input  logic          rst,
  obstacle_scheduler_if.slave bus
);

  localparam logic [31:0] GAP_LIM = 32'(GAP_CYCLES);
  localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, START, RUN, GAP} state_t;

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [3:0]  r_selected;
  logic        r_start;
  logic [7:0]  r_round;
  logic        r_timeout;
  logic [31:0] r_run_cnt;
  logic [31:0] r_gap_cnt;
  logic [11:0] r_rgb_p1;
  logic [11:0] r_x_p1;
  logic [11:0] r_y_p1;

  logic        w_abort;
  logic        w_done;
  logic [31:0] w_run_next;
  logic [11:0] w_slot_rgb;
  logic [11:0] w_slot_x;
  logic [11:0] w_slot_y;

  function automatic logic [1:0] next_enabled(input logic [1:0] cur);
    logic [1:0] idx;
    next_enabled = cur;
    // Scan from farthest to nearest so the nearest enabled successor wins; k=4 lands on cur itself.
    for (int k = 4; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (ENABLE_MASK[idx]) next_enabled = idx;
    end
  endfunction

  function automatic logic [1:0] lowest_enabled();
    lowest_enabled = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (ENABLE_MASK[i]) lowest_enabled = 2'(i);
    end
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] p);
    onehot = 4'b0001 << p;
  endfunction

  assign w_abort    = bus.menu_on | ~bus.play_selected | ~bus.game_on;
  assign w_done     = bus.obst_done[r_ptr];
  assign w_run_next = r_run_cnt + 32'd1;

  always_comb begin
    w_slot_rgb = bus.rgb_obst[11:0];
    w_slot_x   = bus.obst_x_in[11:0];
    w_slot_y   = bus.obst_y_in[11:0];
    for (int i = 1; i < 4; i++) begin
      if (r_ptr == 2'(i)) begin
        w_slot_rgb = bus.rgb_obst[12*i +: 12];
        w_slot_x   = bus.obst_x_in[12*i +: 12];
        w_slot_y   = bus.obst_y_in[12*i +: 12];
      end
    end
  end

  // Pixel/coordinate stage: one register between the selected slot and the outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rgb_p1 <= '0;
      r_x_p1   <= '0;
      r_y_p1   <= '0;
    end else begin
      r_rgb_p1 <= (r_state == RUN) ? w_slot_rgb : bus.rgb_bg;
      r_x_p1   <= (r_state == RUN) ? w_slot_x   : 12'd0;
      r_y_p1   <= (r_state == RUN) ? w_slot_y   : 12'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ptr      <= 2'd0;
      r_selected <= 4'd0;
      r_start    <= 1'b0;
      r_round    <= 8'd0;
      r_timeout  <= 1'b0;
      r_run_cnt  <= 32'd0;
      r_gap_cnt  <= 32'd0;
    end else if (r_state == IDLE) begin
      r_selected <= 4'd0;
      r_start    <= 1'b0;
      if (!w_abort && (ENABLE_MASK != 4'b0000)) begin
        r_state    <= START;
        r_ptr      <= lowest_enabled();
        r_selected <= onehot(lowest_enabled());
        r_start    <= 1'b1;
        r_round    <= 8'd0;
        r_timeout  <= 1'b0;
      end
    end else if (w_abort) begin
      // Leaving the game screen wins over any completion seen this cycle
      r_state    <= IDLE;
      r_selected <= 4'd0;
      r_start    <= 1'b0;
      r_run_cnt  <= 32'd0;
      r_gap_cnt  <= 32'd0;
    end else begin
      case (r_state)
        START: begin
          r_start   <= 1'b0;
          r_run_cnt <= 32'd0;
          r_state   <= RUN;
        end
        RUN: begin
          if (w_done) begin
            r_round   <= sat_inc8(r_round);
            r_ptr     <= next_enabled(r_ptr);
            r_run_cnt <= 32'd0;
            r_gap_cnt <= 32'd0;
            r_state   <= GAP;
          end else if (w_run_next >= TMO_LIM) begin
            r_timeout <= 1'b1;
            r_ptr     <= next_enabled(r_ptr);
            r_run_cnt <= 32'd0;
            r_gap_cnt <= 32'd0;
            r_state   <= GAP;
          end else begin
            r_run_cnt <= w_run_next;
          end
        end
        GAP: begin
          if (r_gap_cnt >= GAP_LIM) begin
            r_state    <= START;
            r_start    <= 1'b1;
            r_selected <= onehot(r_ptr);
            r_gap_cnt  <= 32'd0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 32'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.selected    = r_selected;
  assign bus.start       = r_start;
  assign bus.rgb_out     = r_rgb_p1;
  assign bus.obstacle_x  = r_x_p1;
  assign bus.obstacle_y  = r_y_p1;
  assign bus.round_count = r_round;
  assign bus.timeout_err = r_timeout;

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 16000000; idle cycles between the end of one obstacle and the start of the next.
REQ-002 Parameter TIMEOUT_CYCLES, default 320000000; maximum cycles an obstacle may run before being abandoned.
REQ-003 Parameter ENABLE_MASK, default 4'b1111; bit i set = obstacle i takes part in rotation.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low (rst=0 resets on next clk edge).
REQ-006 game_on  in  1  game screen active.
REQ-007 menu_on  in  1  menu screen active.
REQ-008 play_selected  in  1  play chosen in menu.
REQ-009 obst_done  in  4  bit i = one-cycle completion pulse from obstacle i.
REQ-010 rgb_bg  in  12  background pixel, same timing as obstacle rgb inputs.
REQ-011 rgb_obst  in  48  packed pixel outputs of obstacles 0..3 (bits 12i+11:12i).
REQ-012 obst_x_in, obst_y_in  in  48 each  packed hit coordinates of obstacles 0..3.
REQ-013 selected  out  4  one-hot code of active obstacle (bit i = obstacle i), 0 when none.
REQ-014 start  out  1  one-cycle pulse to the obstacle's done_in start input.
REQ-015 rgb_out  out  12  muxed pixel.
REQ-016 obstacle_x, obstacle_y  out  12 each  muxed hit coordinates of active obstacle.
REQ-017 round_count  out  8  obstacles completed since game start.
REQ-018 timeout_err  out  1  sticky flag, an obstacle exceeded TIMEOUT_CYCLES.

Function
REQ-019 FSM states SHALL be IDLE, START, RUN, GAP; all outputs registered.
REQ-020 abort condition = menu_on | !play_selected | !game_on; in START/RUN/GAP abort SHALL give IDLE next cycle, clearing counters, selected, start.
REQ-021 IDLE: selected=0, start=0; when !abort and ENABLE_MASK!=0 -> START with ptr = lowest enabled index, round_count=0, timeout_err=0.
REQ-022 ENABLE_MASK==0: SHALL remain in IDLE permanently.
REQ-023 START: start=1 for exactly one cycle, selected=one-hot(ptr); -> RUN next cycle.
REQ-024 selected SHALL stay one-hot(ptr) throughout START, RUN, GAP; changes only on entry to START or IDLE.
REQ-025 RUN: 32-bit run counter increments per cycle; obst_done[ptr]=1 -> GAP, round_count+1 (saturate at 255), ptr advances to next enabled index with wrap 3->0.
REQ-026 RUN: run counter reaching TIMEOUT_CYCLES with no done -> timeout_err=1, ptr advance, -> GAP, round_count unchanged.
REQ-027 obst_done bits other than ptr SHALL be ignored in every state.
REQ-028 done and timeout in same cycle: done wins, timeout_err unchanged.
REQ-029 done and abort in same cycle: abort wins, round_count unchanged.
REQ-030 Single enabled obstacle: ptr advances to itself; same obstacle restarts after each gap.
REQ-031 GAP: 32-bit gap counter; after GAP_CYCLES cycles in GAP -> START (GAP_CYCLES=0 gives one GAP cycle).
REQ-032 rgb_out SHALL be rgb_obst[ptr] registered when state is RUN, else rgb_bg registered; latency 1 cycle.
REQ-033 obstacle_x/y SHALL be obst_x_in/obst_y_in[ptr] registered in RUN, else 0; latency 1 cycle.

Reset
REQ-034 rst=0: state IDLE, ptr 0, selected 0, start 0, rgb_out 0, obstacle_x 0, obstacle_y 0, round_count 0, timeout_err 0, counters 0.
REQ-035 rst=0 mid-RUN SHALL take effect on the next edge regardless of obst_done.

Verification (GAP_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-036 game_on=1, play_selected=1, menu_on=0 from reset -> start pulse one cycle, selected=4'b0001; done[0] pulse -> round_count=1, 5 GAP cycles later start with selected=4'b0010.
REQ-037 ENABLE_MASK=4'b1010, run four completions -> selected sequence 0010,1000,0010,1000, round_count=4.
REQ-038 No done for 20 RUN cycles -> timeout_err=1, next obstacle selected, round_count unchanged.
REQ-039 menu_on=1 during RUN with simultaneous done[ptr] -> IDLE, selected=0, round_count unchanged.
REQ-040 RUN with selected=4'b0100, rgb_obst slot2=12'hfff, rgb_bg=12'h000 -> rgb_out=12'hfff one cycle later; done[1] pulse ignored.
REQ-041 rst=0 mid-GAP with round_count=3 -> next cycle all outputs 0, state IDLE.
